dpram_burst_master: RTL and testbench



---
 rtl/dpram_burst_master.sv | 145 ++++++++++++++
 tb/tb_dpram_burst_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_burst_master.sv
// Burst initiator for one port of a 64x8 registered-read dual-port RAM.
// Write bursts stream in on wr_*, read bursts stream out on rd_* through a 4-entry return buffer.
module dpram_burst_master #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic [1:0]        state_dbg
);

    // Every stream (cmd, wr, rd) transfers on a clock edge where valid && ready;
    // valid never depends on ready, and ready may depend only on state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   beats;
    logic              iss_d1, iss_d2, last_d1, last_d2;
    logic [DATA_W-1:0] fifo_data [4];
    logic              fifo_last [4];
    logic [1:0]        wr_ptr, rd_ptr;
    logic [2:0]        fifo_count;

    logic       fifo_empty, cmd_fire, wr_fire, pop, push, issue, last_beat;
    logic [1:0] inflight;
    logic [2:0] occupancy;

    assign fifo_empty = (fifo_count == 3'd0);
    assign rd_valid   = !fifo_empty;
    assign rd_data    = fifo_empty ? '0 : fifo_data[rd_ptr];
    assign rd_last    = !fifo_empty && fifo_last[rd_ptr];

    assign cmd_ready = (state == IDLE);
    assign wr_ready  = (state == WRITE);
    assign busy      = (state != IDLE) || mem_we;
    assign state_dbg = state;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign wr_fire   = wr_valid && wr_ready;
    assign pop       = rd_valid && rd_ready;
    assign push      = iss_d2;
    assign last_beat = (beats == {{ADDR_W{1'b0}}, 1'b1});

    // Reads in the RAM pipeline count against buffer space so a stalled
    // consumer can never overflow the 4-entry return buffer.
    assign inflight  = {1'b0, iss_d1} + {1'b0, iss_d2};
    assign occupancy = fifo_count + {1'b0, inflight};
    assign issue     = (state == READ) && (occupancy < 3'd4);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cmd_fire) state_nxt = cmd_write ? WRITE : READ;
            WRITE: if (wr_fire && last_beat) state_nxt = IDLE;
            READ:  if (issue && last_beat) state_nxt = DRAIN;
            DRAIN: if (pop && rd_last && inflight == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr   <= '0;
            beats      <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            iss_d1     <= 1'b0;
            iss_d2     <= 1'b0;
            last_d1    <= 1'b0;
            last_d2    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            mem_we <= 1'b0;
            if (cmd_fire) begin
                cur_addr <= cmd_addr;
                beats    <= {1'b0, cmd_len} + {{ADDR_W{1'b0}}, 1'b1};
            end
            if (wr_fire) begin
                mem_we   <= 1'b1;
                mem_addr <= cur_addr;
                mem_data <= wr_data;
                cur_addr <= cur_addr + 1'b1;
                beats    <= beats - 1'b1;
            end
            if (issue) begin
                mem_addr <= cur_addr;
                cur_addr <= cur_addr + 1'b1;
                beats    <= beats - 1'b1;
            end
            // Two-stage tag pipe matches mem_addr register plus RAM read register.
            iss_d1  <= issue;
            last_d1 <= issue && last_beat;
            iss_d2  <= iss_d1;
            last_d2 <= last_d1;
            if (push) begin
                fifo_data[wr_ptr] <= mem_q;
                fifo_last[wr_ptr] <= last_d2;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_burst_master.sv
// Bench for dpram_burst_master: behavioural RAM, shadow memory model and
// expected-value queues for the RAM write port and the read stream.
module tb_dpram_burst_master;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr, cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready, rd_last;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic [DW-1:0] mem_q;
    logic [1:0]    state_dbg;

    dpram_burst_master #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .mem_q(mem_q), .state_dbg(state_dbg)
    );

    // clock / reset / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM port model: registered read, write on mem_we
    logic [DW-1:0] ram [64] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    // reference model state
    logic [DW-1:0]   ref_mem [64] = '{default: 8'h00};
    logic [AW+DW-1:0] wexp_q [$];
    int              wcyc_q [$];
    logic [DW:0]     exp_q [$];

    int total = 0;
    int bad   = 0;
    int hs_cyc = 0;
    int last_pop = 0;
    bit rd_first = 0, lat_chk = 0, gap_chk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // scoreboard: RAM write port and read stream
    always @(negedge clk) begin
        if (mem_we) begin
            if (wexp_q.size() == 0) check("we_extra", 1, 0);
            else begin
                logic [AW+DW-1:0] e;
                int c;
                e = wexp_q.pop_front();
                c = wcyc_q.pop_front();
                check("we_addr", 32'(mem_addr), 32'(e[AW+DW-1:DW]));
                check("we_data", 32'(mem_data), 32'(e[DW-1:0]));
                check("we_cyc", cyc, c + 1);
            end
        end
        if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) check("rd_extra", 1, 0);
            else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(e[DW-1:0]));
                check("rd_last", 32'(rd_last), 32'(e[DW]));
                if (rd_first) begin
                    if (lat_chk) check("rd_latency", cyc - hs_cyc, 4);
                    rd_first = 0;
                end else if (gap_chk) begin
                    check("rd_bubble", cyc - last_pop, 1);
                end
                last_pop = cyc;
            end
        end
    end

    // driver tasks
    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] l);
        int t = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        @(negedge clk);
        while (!cmd_ready && t < 300) begin @(negedge clk); t++; end
        if (!cmd_ready) check("cmd_timeout", 0, 1);
        hs_cyc = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // gap: 0 full rate, 1 one beat offered every 3 cycles, 2 random; stop aborts after that many beats
    task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] l, input int gap,
                            input logic [DW-1:0] base, input bit rnd, input int stop);
        int i = 0, t = 0, start;
        logic [DW-1:0] d;
        logic [AW-1:0] wa;
        send_cmd(1'b1, a, l);
        start = cyc;
        while (i <= int'(l) && i < stop && t < 2000) begin
            d = rnd ? 8'($urandom) : base + 8'(i);
            wr_data  = d;
            wr_valid = (gap == 0) ? 1'b1 : (gap == 1) ? (t % 3 == 0) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (wr_valid && wr_ready) begin
                wa = a + AW'(i);
                wexp_q.push_back({wa, d});
                wcyc_q.push_back(cyc);
                ref_mem[wa] = d;
                i++;
            end
            @(posedge clk); #1;
            t++;
        end
        wr_valid = 1'b0;
        if (i > int'(l)) begin
            check("wr_done_ready", 32'(cmd_ready), 1);
            check("wr_done_we", 32'(mem_we), 1);
            if (gap == 0) check("wr_rate", cyc - start, int'(l) + 1);
        end else if (i < stop) begin
            check("wr_timeout", 0, 1);
        end
    endtask

    // mode: 0 rd_ready held high, 1 random, 2 random with a 10-cycle low stretch
    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] l, input int mode);
        int t = 0;
        logic [AW-1:0] ra;
        for (int i = 0; i <= int'(l); i++) begin
            ra = a + AW'(i);
            exp_q.push_back({(i == int'(l)), ref_mem[ra]});
        end
        rd_first = 1; lat_chk = (mode == 0); gap_chk = (mode == 0);
        rd_ready = (mode == 0);
        send_cmd(1'b0, a, l);
        while (exp_q.size() > 0 && t < 3000) begin
            if (mode == 0)                      rd_ready = 1'b1;
            else if (mode == 2 && t >= 3 && t < 13) rd_ready = 1'b0;
            else                                rd_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() > 0) begin
            check("rd_timeout", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
        rd_ready = 1'b0;
        @(negedge clk);
        check("rd_idle_state", 32'(state_dbg), 0);
        check("rd_idle_ready", 32'(cmd_ready), 1);
        check("rd_idle_valid", 32'(rd_valid), 0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_last", 32'(rd_last), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);

        // single write then single read
        do_write(6'd5, 6'd0, 0, 8'hA5, 1'b0, 99);
        do_read(6'd5, 6'd0, 0);

        // wrap burst 60..63, 0..3
        do_write(6'd60, 6'd7, 0, 8'h10, 1'b0, 99);
        do_read(6'd60, 6'd7, 0);

        // full 64-beat burst
        do_write(6'd0, 6'd63, 0, 8'h00, 1'b1, 99);
        do_read(6'd0, 6'd63, 0);

        // read backpressure
        do_read(6'd8, 6'd15, 2);

        // gapped write stream
        do_write(6'd20, 6'd9, 1, 8'h00, 1'b1, 99);
        do_read(6'd20, 6'd9, 1);

        // reset after the 3rd beat of an 8-beat write
        do_write(6'd40, 6'd7, 0, 8'h00, 1'b1, 99);
        do_write(6'd40, 6'd7, 0, 8'h00, 1'b1, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_mem_we", 32'(mem_we), 0);
        check("abort_cmd_ready", 32'(cmd_ready), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_wr_ready", 32'(wr_ready), 0);
        do_read(6'd40, 6'd7, 0);

        // randomized bursts
        for (int k = 0; k < 20; k++) begin
            logic [AW-1:0] a, l;
            a = AW'($urandom);
            l = AW'($urandom_range(0, 20));
            do_write(a, l, int'($urandom_range(0, 2)), 8'h00, 1'b1, 99);
            do_read(AW'($urandom), AW'($urandom_range(0, 20)), int'($urandom_range(0, 2)));
        end

        repeat (4) @(posedge clk);
        check("we_queue_empty", 32'(wexp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
